// File: rtl/fsm_1_supervisor.sv
// ============================================================================
// fsm_1_supervisor : initiator side of the go/kill/done job handshake with a
//                    watchdog, software cancel and saturating status counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fsm_1_supervisor #(
  parameter int TIMEOUT     = 200,
  parameter int KILL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cancel,
  input  logic       done,
  output logic       go,
  output logic       kill,
  output logic       busy,
  output logic       ok,
  output logic       timed_out,
  output logic       cancelled,
  output logic [7:0] job_count,
  output logic [7:0] fail_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_KILL   = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  localparam logic [7:0] c_timer_last = 8'(TIMEOUT - 1);
  localparam logic [3:0] c_kill_last  = 4'(KILL_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_timer;
  logic [7:0] w_timer_nxt;
  logic [3:0] r_kcnt;
  logic [3:0] w_kcnt_nxt;

  logic       r_go;
  logic       r_kill;
  logic       r_busy;
  logic       r_ok;
  logic       r_timed_out;
  logic       r_cancelled;
  logic [7:0] r_job_count;
  logic [7:0] r_fail_count;

  logic       w_go_nxt;
  logic       w_kill_nxt;
  logic       w_busy_nxt;
  logic       w_ok_nxt;
  logic       w_timed_out_nxt;
  logic       w_cancelled_nxt;
  logic [7:0] w_job_count_nxt;
  logic [7:0] w_fail_count_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_timer      <= 8'd0;
      r_kcnt       <= 4'd0;
      r_go         <= 1'b0;
      r_kill       <= 1'b0;
      r_busy       <= 1'b0;
      r_ok         <= 1'b0;
      r_timed_out  <= 1'b0;
      r_cancelled  <= 1'b0;
      r_job_count  <= 8'd0;
      r_fail_count <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_kcnt       <= w_kcnt_nxt;
      r_go         <= w_go_nxt;
      r_kill       <= w_kill_nxt;
      r_busy       <= w_busy_nxt;
      r_ok         <= w_ok_nxt;
      r_timed_out  <= w_timed_out_nxt;
      r_cancelled  <= w_cancelled_nxt;
      r_job_count  <= w_job_count_nxt;
      r_fail_count <= w_fail_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_kcnt_nxt       = r_kcnt;
    w_ok_nxt         = 1'b0;
    w_timed_out_nxt  = 1'b0;
    w_cancelled_nxt  = 1'b0;
    w_job_count_nxt  = r_job_count;
    w_fail_count_nxt = r_fail_count;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        w_state_nxt = ST_WAIT;
        w_timer_nxt = 8'd0;
      end

      // Exit priority: done, then cancel, then watchdog expiry.
      ST_WAIT: begin
        w_timer_nxt = r_timer + 8'd1;
        if (done) begin
          w_state_nxt     = ST_IDLE;
          w_ok_nxt        = 1'b1;
          w_job_count_nxt = (r_job_count == 8'hFF) ? r_job_count : r_job_count + 8'd1;
        end else if (cancel) begin
          w_state_nxt      = ST_KILL;
          w_kcnt_nxt       = 4'd0;
          w_cancelled_nxt  = 1'b1;
          w_fail_count_nxt = (r_fail_count == 8'hFF) ? r_fail_count : r_fail_count + 8'd1;
        end else if (r_timer == c_timer_last) begin
          w_state_nxt      = ST_KILL;
          w_kcnt_nxt       = 4'd0;
          w_timed_out_nxt  = 1'b1;
          w_fail_count_nxt = (r_fail_count == 8'hFF) ? r_fail_count : r_fail_count + 8'd1;
        end
      end

      ST_KILL: begin
        if (r_kcnt == c_kill_last) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_kcnt_nxt = r_kcnt + 4'd1;
        end
      end

      ST_DRAIN: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Level outputs are registered copies of the state being entered.
    w_go_nxt   = (w_state_nxt == ST_LAUNCH);
    w_kill_nxt = (w_state_nxt == ST_KILL);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign go         = r_go;
  assign kill       = r_kill;
  assign busy       = r_busy;
  assign ok         = r_ok;
  assign timed_out  = r_timed_out;
  assign cancelled  = r_cancelled;
  assign job_count  = r_job_count;
  assign fail_count = r_fail_count;

endmodule

`default_nettype wire
